// File: rtl/game_round_judge.sv
// game_round_judge: referee between the play-field logic and the game FSM.
// Counts coins per round and per game, confirms enemy collisions over
// consecutive frames, and pulses the matching round-won or collision output.
module game_round_judge #(
    parameter int unsigned SIZE        = 16,
    parameter int unsigned TARGET_BASE = 3,
    parameter int unsigned HIT_FRAMES  = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [5:0] state,
    input  logic       frame_tick,
    input  logic       coin_pulse,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    input  logic [9:0] enemy_x,
    input  logic [9:0] enemy_y,
    output logic       wonFirstRound,
    output logic       wonSecondRound,
    output logic       wonThirdRound,
    output logic       wonFourthRound,
    output logic       collidedWithEnemy,
    output logic [3:0] round_score,
    output logic [7:0] total_score
);

    localparam logic [5:0] ST_INI    = 6'b000001;
    localparam logic [5:0] ST_FIRST  = 6'b000010;
    localparam logic [5:0] ST_SECOND = 6'b000100;
    localparam logic [5:0] ST_THIRD  = 6'b001000;
    localparam logic [5:0] ST_FIN    = 6'b010000;
    localparam int unsigned HW = $clog2(HIT_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, PLAY, HOLD} judge_t;

    judge_t          jstate;
    logic [1:0]      idx;
    logic [5:0]      latched_state;
    logic [HW-1:0]   hit_cnt;
    logic [3:0]      won_q;

    logic            is_round;
    logic [1:0]      state_idx;
    logic [10:0]     dx;
    logic [10:0]     dy;
    logic            overlap;
    logic [3:0]      target;
    logic            win_now;
    logic            hit_now;

    assign wonFirstRound  = won_q[0];
    assign wonSecondRound = won_q[1];
    assign wonThirdRound  = won_q[2];
    assign wonFourthRound = won_q[3];

    // Decode round state, box overlap and the win/collision conditions
    always_comb begin
        is_round  = 1'b1;
        state_idx = 2'd0;
        case (state)
            ST_FIRST:  state_idx = 2'd0;
            ST_SECOND: state_idx = 2'd1;
            ST_THIRD:  state_idx = 2'd2;
            ST_FIN:    state_idx = 2'd3;
            default:   is_round  = 1'b0;
        endcase
        dx = ({1'b0, player_x} >= {1'b0, enemy_x}) ? ({1'b0, player_x} - {1'b0, enemy_x})
                                                   : ({1'b0, enemy_x} - {1'b0, player_x});
        dy = ({1'b0, player_y} >= {1'b0, enemy_y}) ? ({1'b0, player_y} - {1'b0, enemy_y})
                                                   : ({1'b0, enemy_y} - {1'b0, player_y});
        overlap = (dx < 11'(SIZE)) && (dy < 11'(SIZE));
        target  = 4'(TARGET_BASE) + {1'b0, idx, 1'b0};
        win_now = (round_score == target);
        hit_now = (hit_cnt == HW'(HIT_FRAMES));
    end

    // Judge FSM with registered pulses and score counters
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            jstate            <= IDLE;
            idx               <= '0;
            latched_state     <= '0;
            hit_cnt           <= '0;
            won_q             <= '0;
            collidedWithEnemy <= 1'b0;
            round_score       <= '0;
            total_score       <= '0;
        end else begin
            won_q             <= '0;
            collidedWithEnemy <= 1'b0;
            case (jstate)
                IDLE: begin
                    if (is_round) begin
                        jstate        <= PLAY;
                        idx           <= state_idx;
                        latched_state <= state;
                        round_score   <= '0;
                        hit_cnt       <= '0;
                    end
                end
                PLAY, HOLD: begin
                    // A state change ends the round before any pulse or count is considered
                    if (state != latched_state) begin
                        if (is_round) begin
                            jstate        <= PLAY;
                            idx           <= state_idx;
                            latched_state <= state;
                            round_score   <= '0;
                            hit_cnt       <= '0;
                        end else begin
                            jstate <= IDLE;
                        end
                    end else if (jstate == PLAY) begin
                        // Collision outranks a win; the deciding cycle ignores coins and ticks
                        if (hit_now) begin
                            collidedWithEnemy <= 1'b1;
                            jstate            <= HOLD;
                        end else if (win_now) begin
                            won_q  <= 4'(4'b0001 << idx);
                            jstate <= HOLD;
                        end else begin
                            if (coin_pulse) begin
                                if (round_score != 4'hF) round_score <= round_score + 1'b1;
                                if (total_score != 8'hFF) total_score <= total_score + 1'b1;
                            end
                            if (frame_tick) hit_cnt <= overlap ? hit_cnt + 1'b1 : '0;
                        end
                    end
                end
                default: jstate <= IDLE;
            endcase
            if (state == ST_INI) total_score <= '0;
        end
    end

endmodule

// File: tb/tb_game_round_judge.sv
// tb_game_round_judge: directed scenarios plus randomized play checked
// against a behavioural model of the referee rules.
module tb_game_round_judge;

    localparam logic [5:0] INI    = 6'b000001;
    localparam logic [5:0] FIRST  = 6'b000010;
    localparam logic [5:0] SECOND = 6'b000100;
    localparam logic [5:0] THIRD  = 6'b001000;
    localparam logic [5:0] FIN    = 6'b010000;
    localparam logic [5:0] WIN    = 6'b100000;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [5:0] state = INI;
    logic       frame_tick = 1'b0;
    logic       coin_pulse = 1'b0;
    logic [9:0] player_x = 10'd100;
    logic [9:0] player_y = 10'd100;
    logic [9:0] enemy_x = 10'd300;
    logic [9:0] enemy_y = 10'd300;
    logic       wonFirstRound, wonSecondRound, wonThirdRound, wonFourthRound;
    logic       collidedWithEnemy;
    logic [3:0] round_score;
    logic [7:0] total_score;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: is a round being refereed, has it been decided, etc.
    bit       m_active;
    bit       m_done;
    int       m_round;
    logic [5:0] m_lat;
    int       m_rs;
    int       m_ts;
    int       m_hits;
    bit [3:0] m_won;
    bit       m_col;

    game_round_judge #(.SIZE(16), .TARGET_BASE(3), .HIT_FRAMES(2)) dut (
        .Clk(Clk), .Reset(Reset), .state(state), .frame_tick(frame_tick),
        .coin_pulse(coin_pulse), .player_x(player_x), .player_y(player_y),
        .enemy_x(enemy_x), .enemy_y(enemy_y),
        .wonFirstRound(wonFirstRound), .wonSecondRound(wonSecondRound),
        .wonThirdRound(wonThirdRound), .wonFourthRound(wonFourthRound),
        .collidedWithEnemy(collidedWithEnemy), .round_score(round_score),
        .total_score(total_score)
    );

    always #5 Clk = ~Clk;

    wire [16:0] dut_vec = {wonFirstRound, wonSecondRound, wonThirdRound, wonFourthRound,
                           collidedWithEnemy, round_score, total_score};

    function automatic logic [16:0] exp_vec();
        return {m_won[0], m_won[1], m_won[2], m_won[3], m_col, 4'(m_rs), 8'(m_ts)};
    endfunction

    function automatic int round_of(input logic [5:0] s);
        case (s)
            FIRST:   return 0;
            SECOND:  return 1;
            THIRD:   return 2;
            FIN:     return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic model_reset();
        m_active = 0; m_done = 0; m_round = 0; m_lat = '0;
        m_rs = 0; m_ts = 0; m_hits = 0; m_won = '0; m_col = 0;
    endtask

    task automatic model_step();
        int r;
        bit ov;
        r  = round_of(state);
        ov = (absdiff(int'(player_x), int'(enemy_x)) < 16) &&
             (absdiff(int'(player_y), int'(enemy_y)) < 16);
        m_won = '0;
        m_col = 0;
        if (!m_active || state != m_lat) begin
            if (r >= 0) begin
                m_active = 1; m_done = 0; m_round = r; m_lat = state;
                m_rs = 0; m_hits = 0;
            end else begin
                m_active = 0;
            end
        end else if (!m_done) begin
            if (m_hits >= 2) begin
                m_col = 1; m_done = 1;
            end else if (m_rs == 3 + 2 * m_round) begin
                m_won[m_round] = 1; m_done = 1;
            end else begin
                if (coin_pulse) begin
                    m_rs = (m_rs < 15) ? m_rs + 1 : 15;
                    m_ts = (m_ts < 255) ? m_ts + 1 : 255;
                end
                if (frame_tick) m_hits = ov ? m_hits + 1 : 0;
            end
        end
        if (state == INI) m_ts = 0;
    endtask

    // One clock edge; model sees the same inputs the DUT samples
    task automatic tick();
        @(posedge Clk);
        if (Reset) model_reset();
        else model_step();
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (dut_vec !== 17'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected %h", dut_vec, 17'h0);
        end
        Reset = 1'b0;
        state = INI;
        tick();
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL reset_release: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_first_round();
        int pulses;
        pulses = 0;
        player_x = 10'd100; player_y = 10'd100; enemy_x = 10'd300; enemy_y = 10'd300;
        state = FIRST;
        tick();
        coin_pulse = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (wonFirstRound) pulses++;
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL first_cycle%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        coin_pulse = 1'b0;
        n_cmp++;
        if (pulses !== 1) begin
            n_bad++;
            $display("FAIL first_pulse_count: got %0d expected 1", pulses);
        end
        n_cmp++;
        if (round_score !== 4'd3 || total_score !== 8'd3) begin
            n_bad++;
            $display("FAIL first_scores: got %0d/%0d expected 3/3", round_score, total_score);
        end
    endtask

    task automatic test_second_round();
        int pulses;
        pulses = 0;
        state = SECOND;
        tick();
        for (int i = 0; i < 4; i++) begin
            coin_pulse = 1'b1; tick();
            coin_pulse = 1'b0; tick();
            if (wonSecondRound) pulses++;
        end
        n_cmp++;
        if (pulses !== 0 || round_score !== 4'd4) begin
            n_bad++;
            $display("FAIL second_four_coins: got pulses=%0d rs=%0d expected 0/4", pulses, round_score);
        end
        coin_pulse = 1'b1; tick();
        coin_pulse = 1'b0; tick();
        n_cmp++;
        if (wonSecondRound !== 1'b1 || dut_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL second_win_pulse: got %h expected %h", dut_vec, exp_vec());
        end
        state = THIRD;
        tick();
        n_cmp++;
        if (round_score !== 4'd0 || total_score !== 8'd8) begin
            n_bad++;
            $display("FAIL third_entry: got %0d/%0d expected 0/8", round_score, total_score);
        end
    endtask

    task automatic test_collision();
        int cols;
        cols = 0;
        player_x = 10'd100; player_y = 10'd100; enemy_x = 10'd110; enemy_y = 10'd108;
        frame_tick = 1'b1;
        tick();
        tick();
        frame_tick = 1'b0;
        n_cmp++;
        if (collidedWithEnemy !== 1'b0) begin
            n_bad++;
            $display("FAIL collision_early: got %b expected 0", collidedWithEnemy);
        end
        tick();
        n_cmp++;
        if (collidedWithEnemy !== 1'b1 || dut_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL collision_pulse: got %h expected %h", dut_vec, exp_vec());
        end
        state = FIN;
        enemy_x = 10'd116; enemy_y = 10'd100;
        tick();
        frame_tick = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 5) frame_tick = 1'b0;
            tick();
            if (collidedWithEnemy) cols++;
        end
        n_cmp++;
        if (cols !== 0 || dut_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL boundary_no_overlap: got cols=%0d vec=%h expected 0 %h", cols, dut_vec, exp_vec());
        end
    endtask

    task automatic test_counter_clear();
        int cols;
        cols = 0;
        frame_tick = 1'b1;
        enemy_x = 10'd110; enemy_y = 10'd108; tick();
        enemy_x = 10'd116; enemy_y = 10'd100; tick();
        enemy_x = 10'd110; enemy_y = 10'd108; tick();
        frame_tick = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (collidedWithEnemy) cols++;
        end
        n_cmp++;
        if (cols !== 0 || dut_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL counter_clear: got cols=%0d vec=%h expected 0 %h", cols, dut_vec, exp_vec());
        end
    endtask

    task automatic test_win_and_collision();
        int wins;
        int cols;
        wins = 0; cols = 0;
        state = INI; tick();
        state = FIRST; tick();
        enemy_x = 10'd110; enemy_y = 10'd108;
        coin_pulse = 1'b1; tick(); tick();
        coin_pulse = 1'b0; frame_tick = 1'b1; tick();
        coin_pulse = 1'b1; tick();
        coin_pulse = 1'b0; frame_tick = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (collidedWithEnemy) cols++;
            if (wonFirstRound | wonSecondRound | wonThirdRound | wonFourthRound) wins++;
        end
        n_cmp++;
        if (cols !== 1 || wins !== 0) begin
            n_bad++;
            $display("FAIL win_vs_collision: got cols=%0d wins=%0d expected 1/0", cols, wins);
        end
        n_cmp++;
        if (round_score !== 4'd3 || total_score !== 8'd3) begin
            n_bad++;
            $display("FAIL win_vs_collision_score: got %0d/%0d expected 3/3", round_score, total_score);
        end
    endtask

    task automatic test_random();
        logic [5:0] picks [7];
        picks[0] = INI; picks[1] = FIRST; picks[2] = SECOND; picks[3] = THIRD;
        picks[4] = FIN; picks[5] = WIN; picks[6] = 6'b000110;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                state = picks[$urandom_range(0, 6)];
                if (state == 6'b000110) state = 6'($urandom);
            end
            Reset      = ($urandom_range(0, 799) == 0);
            coin_pulse = ($urandom_range(0, 2) == 0);
            frame_tick = ($urandom_range(0, 3) == 0);
            player_x   = 10'($urandom);
            player_y   = 10'($urandom);
            enemy_x    = 10'(int'(player_x) + $urandom_range(0, 36) - 18);
            enemy_y    = 10'(int'(player_y) + $urandom_range(0, 36) - 18);
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL random_cycle%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        Reset = 1'b0;
        coin_pulse = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic test_reset_mid_round();
        state = INI; tick();
        state = FIRST;
        player_x = 10'd100; player_y = 10'd100; enemy_x = 10'd300; enemy_y = 10'd300;
        tick();
        coin_pulse = 1'b1; tick(); tick();
        coin_pulse = 1'b0;
        n_cmp++;
        if (round_score !== 4'd2) begin
            n_bad++;
            $display("FAIL midreset_setup: got %0d expected 2", round_score);
        end
        #2;
        Reset = 1'b1;
        #1;
        n_cmp++;
        if (dut_vec !== 17'h0) begin
            n_bad++;
            $display("FAIL midreset_async: got %h expected %h", dut_vec, 17'h0);
        end
        tick();
        Reset = 1'b0;
        state = INI;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (dut_vec !== 17'h0 || dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL midreset_after%0d: got %h expected %h", i, dut_vec, 17'h0);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_round();
        test_second_round();
        test_collision();
        test_counter_clear();
        test_win_and_collision();
        test_random();
        test_reset_mid_round();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
